// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// MISALIGN_TRAP_EN (optional) is consumed by next_pc_logic and pc_fetch_unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    // Encodings 010/011 are not branch conditions and never take.
    function automatic logic branch_taken(
        input logic [2:0] funct3,
        input logic       zero,
        input logic       signed_less,
        input logic       unsigned_less
    );
        case (funct3)
            F3_BEQ:  return zero;
            F3_BNE:  return !zero;
            F3_BLT:  return signed_less;
            F3_BGE:  return !signed_less;
            F3_BLTU: return unsigned_less;
            F3_BGEU: return !unsigned_less;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational branch decode and next-PC selection for the fetch stage.
// MISALIGN_TRAP_EN defined: misaligned redirect targets are flagged instead of silently aligned.
module next_pc_logic
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        branch_i,
    input  logic [2:0]  funct3_i,
    input  logic        jump_i,
    input  logic        jump_reg_i,
    input  logic [31:0] imm_ext_i,
    input  logic [31:0] alu_result_i,
    input  logic        zero_i,
    input  logic        signed_less_i,
    input  logic        unsigned_less_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic [31:0] rel_target;
    logic [31:0] target;
    logic        taken;
    logic        redirect;

    assign rel_target = pc_i + imm_ext_i;
    assign taken      = branch_i && branch_taken(funct3_i, zero_i, signed_less_i, unsigned_less_i);
    assign redirect   = jump_reg_i || jump_i || taken;

    // JALR clears bit 0 of rs1+imm; JumpReg outranks Jump and branches.
    assign target    = jump_reg_i ? (alu_result_i & 32'hFFFF_FFFE) : rel_target;
    assign next_pc_o = redirect ? (target & 32'hFFFF_FFFC) : pc_plus4_i;

`ifdef MISALIGN_TRAP_EN
    assign misalign_o = redirect && (target[1:0] != 2'b00);
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, imem request/valid handshake, fetch timeout, commit redirect.
// MISALIGN_TRAP_EN defined: a misaligned committed redirect halts fetch with FetchErr.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        Stall,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        Branch,
    input  logic [2:0]  Funct3,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    input  logic        signedLess,
    input  logic        unsignedLess,
    output logic        FetchErr
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  instr_q;
    logic         instr_valid_q;
    logic         imem_req_q;
    logic         fetch_err_q;
    logic [7:0]   cnt_q;
    logic         misalign;

    assign PCPlus4 = pc_q + 32'd4;

    next_pc_logic u_next_pc (
        .pc_i            (pc_q),
        .pc_plus4_i      (PCPlus4),
        .branch_i        (Branch),
        .funct3_i        (Funct3),
        .jump_i          (Jump),
        .jump_reg_i      (JumpReg),
        .imm_ext_i       (ImmExt),
        .alu_result_i    (ALUResult),
        .zero_i          (Zero),
        .signed_less_i   (signedLess),
        .unsigned_less_i (unsignedLess),
        .next_pc_o       (pc_d),
        .misalign_o      (misalign)
    );

    // state | meaning
    // IDLE  | one settling cycle after reset
    // REQ   | imem_req pulsed, imem_addr = PC
    // WAIT  | waiting for imem_valid, timeout counter running
    // HOLD  | Instr/PC presented; commit when Stall drops
    // HALT  | fetch error, frozen until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            fetch_err_q   <= 1'b0;
            cnt_q         <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: begin
                    state_q    <= WAIT;
                    imem_req_q <= 1'b0;
                    cnt_q      <= 8'd0;
                end
                WAIT: begin
                    // A response on the timeout cycle takes precedence over the error.
                    if (imem_valid) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= HOLD;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        fetch_err_q <= 1'b1;
                        state_q     <= HALT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        instr_valid_q <= 1'b0;
                        if (misalign) begin
                            fetch_err_q <= 1'b1;
                            state_q     <= HALT;
                        end else begin
                            pc_q       <= pc_d;
                            imem_req_q <= 1'b1;
                            state_q    <= REQ;
                        end
                    end
                end
                HALT: begin
                    instr_valid_q <= 1'b0;
                    imem_req_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign PC         = pc_q;
    assign Instr      = instr_q;
    assign InstrValid = instr_valid_q;
    assign FetchErr   = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (default and MISALIGN_TRAP_EN builds).
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        Stall = 1'b0;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Branch = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic        Jump = 1'b0;
    logic        JumpReg = 1'b0;
    logic [31:0] ImmExt = 32'd0;
    logic [31:0] ALUResult = 32'd0;
    logic        Zero = 1'b0;
    logic        signedLess = 1'b0;
    logic        unsignedLess = 1'b0;
    logic        FetchErr;

    int total = 0;
    int bad = 0;

    // Memory responder: automatic one-cycle-latency reply, or manual drive.
    logic        resp_en = 1'b1;
    logic        auto_valid = 1'b0;
    logic [31:0] auto_rdata = 32'd0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic        man_valid = 1'b0;
    logic [31:0] man_rdata = 32'd0;

    assign imem_valid = resp_en ? auto_valid : man_valid;
    assign imem_rdata = resp_en ? auto_rdata : man_rdata;

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    always @(negedge clk) begin
        auto_valid = resp_en && prev_req;
        auto_rdata = data_of(prev_addr);
        prev_req   = imem_req;
        prev_addr  = imem_addr;
    end

    pc_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .Instr        (Instr),
        .InstrValid   (InstrValid),
        .Stall        (Stall),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .Branch       (Branch),
        .Funct3       (Funct3),
        .Jump         (Jump),
        .JumpReg      (JumpReg),
        .ImmExt       (ImmExt),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .signedLess   (signedLess),
        .unsignedLess (unsignedLess),
        .FetchErr     (FetchErr)
    );

    typedef struct {
        logic        br;
        logic [2:0]  f3;
        logic        j;
        logic        jr;
        logic [31:0] imm;
        logic [31:0] alu;
        logic        z;
        logic        sl;
        logic        ul;
        logic [31:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        Branch = 1'b0; Funct3 = 3'b000; Jump = 1'b0; JumpReg = 1'b0;
        ImmExt = 32'd0; ALUResult = 32'd0; Zero = 1'b0; signedLess = 1'b0; unsignedLess = 1'b0;
    endtask

    // Wait for the request to exp_pc, then for the presented instruction.
    task automatic fetch_one(input logic [31:0] exp_pc, input string tag);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin tick(); n++; end
        total++;
        if (imem_req !== 1'b1) begin
            bad++; $display("FAIL %s_req: no imem_req within %0d cycles", tag, n); return;
        end
        total++;
        if (imem_addr !== exp_pc) begin
            bad++; $display("FAIL %s_addr: got %h expected %h", tag, imem_addr, exp_pc);
        end
        n = 0;
        while (InstrValid !== 1'b1 && n < 8) begin tick(); n++; end
        total++;
        if (InstrValid !== 1'b1) begin
            bad++; $display("FAIL %s_valid: InstrValid not seen within %0d cycles", tag, n); return;
        end
        total++;
        if (Instr !== data_of(exp_pc)) begin
            bad++; $display("FAIL %s_instr: got %h expected %h", tag, Instr, data_of(exp_pc));
        end
        total++;
        if (PC !== exp_pc || PCPlus4 !== exp_pc + 32'd4) begin
            bad++; $display("FAIL %s_pc: got PC=%h PCPlus4=%h expected %h/%h", tag, PC, PCPlus4, exp_pc, exp_pc + 32'd4);
        end
    endtask

    task automatic commit(input vec_t v);
        Branch = v.br; Funct3 = v.f3; Jump = v.j; JumpReg = v.jr; ImmExt = v.imm;
        ALUResult = v.alu; Zero = v.z; signedLess = v.sl; unsignedLess = v.ul;
        tick();
        clear_ctl();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++;
        if (PC !== RST_PC || Instr !== 32'd0 || InstrValid !== 1'b0 || imem_req !== 1'b0 || FetchErr !== 1'b0) begin
            bad++;
            $display("FAIL reset: got PC=%h Instr=%h IV=%b req=%b err=%b expected %h/0/0/0/0",
                     PC, Instr, InstrValid, imem_req, FetchErr, RST_PC);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            fetch_one(RST_PC + 32'(4 * i), "seq");
            if (i < 2) begin
                tick();
                total++;
                if (InstrValid !== 1'b0 || imem_req !== 1'b1) begin
                    bad++; $display("FAIL seq_commit: got IV=%b req=%b expected 0/1", InstrValid, imem_req);
                end
            end
        end
    endtask

    task automatic test_branches();
        vec_t v[14];
        //        br    f3      j     jr    imm            alu            z     sl    ul    exp
        v[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'hBFC0_000C};
        v[1]  = '{1'b0, 3'b000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 32'hBFC0_0010};
        v[2]  = '{1'b1, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hBFC0_0000};
        v[3]  = '{1'b1, 3'b001, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hBFC0_0004};
        v[4]  = '{1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 1'b0, 1'b0, 32'hBFC0_0104};
        v[5]  = '{1'b1, 3'b100, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 1'b0, 32'hBFC0_0114};
        v[6]  = '{1'b1, 3'b101, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 1'b0, 32'hBFC0_0118};
        v[7]  = '{1'b1, 3'b110, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 1'b0, 32'hBFC0_011C};
        v[8]  = '{1'b1, 3'b111, 1'b0, 1'b0, 32'hFFFF_FF00, 32'h0,         1'b0, 1'b0, 1'b0, 32'hBFC0_001C};
        v[9]  = '{1'b1, 3'b010, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 1'b1, 1'b1, 32'hBFC0_0020};
        v[10] = '{1'b0, 3'b000, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 1'b0, 1'b0, 32'hBFC0_0060};
        v[11] = '{1'b0, 3'b000, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0125, 1'b0, 1'b0, 1'b0, 32'h0000_0124};
        v[12] = '{1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0128};
        v[13] = '{1'b0, 3'b000, 1'b0, 1'b1, 32'h0,         32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC};
        for (int i = 0; i < 14; i++) begin
            commit(v[i]);
            fetch_one(v[i].exp, $sformatf("br%0d", i));
        end
    endtask

    task automatic test_wrap();
        vec_t none;
        none = '{1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        total++;
        if (PCPlus4 !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_pcplus4: got %h expected 00000000", PCPlus4);
        end
        commit(none);
        fetch_one(32'h0000_0000, "wrap");
    endtask

    task automatic test_stall();
        vec_t none;
        none = '{1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (imem_req !== 1'b0 || InstrValid !== 1'b1 || PC !== 32'h0 || Instr !== data_of(32'h0)) begin
                bad++;
                $display("FAIL stall%0d: got req=%b IV=%b PC=%h Instr=%h expected 0/1/00000000/%h",
                         i, imem_req, InstrValid, PC, Instr, data_of(32'h0));
            end
        end
        Stall = 1'b0;
        commit(none);
        total++;
        if (PC !== 32'h0000_0004 || imem_req !== 1'b1) begin
            bad++; $display("FAIL stall_release: got PC=%h req=%b expected 00000004/1", PC, imem_req);
        end
        fetch_one(32'h0000_0004, "stall_next");
    endtask

    task automatic test_misalign();
        vec_t v;
        v = '{1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_0006, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        commit(v);
`ifdef MISALIGN_TRAP_EN
        total++;
        if (FetchErr !== 1'b1 || PC !== 32'h0000_0004) begin
            bad++; $display("FAIL misalign_trap: got err=%b PC=%h expected 1/00000004", FetchErr, PC);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (imem_req !== 1'b0 || InstrValid !== 1'b0 || PC !== 32'h0000_0004) begin
                bad++; $display("FAIL misalign_halt%0d: got req=%b IV=%b PC=%h expected 0/0/00000004", i, imem_req, InstrValid, PC);
            end
        end
`else
        fetch_one(32'h0000_0008, "misalign_forced");
        total++;
        if (FetchErr !== 1'b0) begin
            bad++; $display("FAIL misalign_noerr: got err=%b expected 0", FetchErr);
        end
`endif
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin tick(); n++; end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            bad++; $display("FAIL %s: got req=%b addr=%h expected 1/%h", tag, imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_timeout();
        resp_en = 1'b0; man_valid = 1'b0; prev_req = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        wait_req("to_req");
        repeat (16) tick();
        total++;
        if (FetchErr !== 1'b0) begin
            bad++; $display("FAIL to_early: got err=%b expected 0 after 15 WAIT edges", FetchErr);
        end
        tick();
        total++;
        if (FetchErr !== 1'b1) begin
            bad++; $display("FAIL to_err: got err=%b expected 1 after 16 WAIT edges", FetchErr);
        end
        repeat (3) tick();
        total++;
        if (FetchErr !== 1'b1 || imem_req !== 1'b0 || InstrValid !== 1'b0 || PC !== RST_PC) begin
            bad++; $display("FAIL to_halt: got err=%b req=%b IV=%b PC=%h expected 1/0/0/%h", FetchErr, imem_req, InstrValid, PC, RST_PC);
        end
        rst_n = 1'b0; tick();
        total++;
        if (FetchErr !== 1'b0 || PC !== RST_PC) begin
            bad++; $display("FAIL to_reset: got err=%b PC=%h expected 0/%h", FetchErr, PC, RST_PC);
        end
        rst_n = 1'b1;
        wait_req("to_restart");
        // Response on the very cycle the timeout would fire.
        repeat (16) tick();
        man_valid = 1'b1; man_rdata = 32'h1234_5678;
        tick();
        man_valid = 1'b0;
        total++;
        if (InstrValid !== 1'b1 || FetchErr !== 1'b0 || Instr !== 32'h1234_5678) begin
            bad++; $display("FAIL to_race: got IV=%b err=%b Instr=%h expected 1/0/12345678", InstrValid, FetchErr, Instr);
        end
    endtask

    task automatic test_reset_mid_wait();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        wait_req("mw_req");
        tick();
        rst_n = 1'b0; tick();
        total++;
        if (InstrValid !== 1'b0 || PC !== RST_PC || imem_req !== 1'b0) begin
            bad++; $display("FAIL mw_reset: got IV=%b PC=%h req=%b expected 0/%h/0", InstrValid, PC, imem_req, RST_PC);
        end
        man_valid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC || InstrValid !== 1'b0) begin
            bad++; $display("FAIL mw_req: got req=%b addr=%h IV=%b expected 1/%h/0", imem_req, imem_addr, InstrValid, RST_PC);
        end
        tick();
        man_valid = 1'b0;
        total++;
        if (InstrValid !== 1'b0 || Instr !== 32'd0) begin
            bad++; $display("FAIL mw_late_ignored: got IV=%b Instr=%h expected 0/00000000", InstrValid, Instr);
        end
        tick();
        man_valid = 1'b1; man_rdata = data_of(RST_PC);
        tick();
        man_valid = 1'b0;
        total++;
        if (InstrValid !== 1'b1 || Instr !== data_of(RST_PC) || PC !== RST_PC) begin
            bad++; $display("FAIL mw_first: got IV=%b Instr=%h PC=%h expected 1/%h/%h", InstrValid, Instr, PC, data_of(RST_PC), RST_PC);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ctl();
        test_reset();
        test_sequential();
        test_branches();
        test_wrap();
        test_stall();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
